counter_ctrl: RTL and testbench

Control front end that sits directly upstream of the 3-bit up/down counter and drives its enable and dir inputs.
- Conditions the raw board inputs (step button, mode button, direction switch) with synchronisers and debouncers.
- Produces single-cycle enable pulses, either one per step-button press (MANUAL) or one per prescaler period (AUTO).
- Holds dir stable around every pulse.

---
 rtl/counter_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Front end for the 3-bit up/down counter: synchronises and debounces the board
// inputs, then issues single-cycle enable pulses (manual step or auto prescaler).
//
// state  | meaning
// MANUAL | one enable pulse per debounced step press, prescaler parked at 0
// AUTO   | one enable pulse every TICK_DIV cycles, step presses ignored
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_step,
  input  logic btn_mode,
  input  logic sw_dir,
  output logic enable,
  output logic dir,
  output logic mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  // bit 0 = step, bit 1 = mode, bit 2 = direction switch
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    db_q, db_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [1:0]    db_prev_q;
  logic          step_rise, mode_rise;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enable_q, enable_d;
  logic          dir_q, dir_d;

  assign raw = {sw_dir, btn_mode, btn_step};

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign step_rise = db_q[0] & ~db_prev_q[0];
  assign mode_rise = db_q[1] & ~db_prev_q[1];

  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    enable_d = 1'b0;
    case (state_q)
      MANUAL: begin
        // a mode press wins over a coincident step press
        if (mode_rise) begin
          state_d = AUTO;
        end else begin
          enable_d = step_rise;
        end
      end
      AUTO: begin
        if (mode_rise) begin
          state_d = MANUAL;
        end else if (presc_q == PRESC_LAST) begin
          enable_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    endcase
    // dir only moves on edges that do not raise enable, so it is settled around every pulse
    dir_d = enable_d ? dir_q : db_q[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      state_q   <= MANUAL;
      presc_q   <= '0;
      enable_q  <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q[1:0];
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q   <= state_d;
      presc_q   <= presc_d;
      enable_q  <= enable_d;
      dir_q     <= dir_d;
    end
  end

  assign enable = enable_q;
  assign dir    = dir_q;
  assign mode   = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_step = 1'b0;
  logic btn_mode = 1'b0;
  logic sw_dir = 1'b0;
  logic enable, dir, mode;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .sw_dir  (sw_dir),
    .enable  (enable),
    .dir     (dir),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Watch n falling edges; report pulse count and 1-based index of first/last pulse.
  task automatic run(input int n, output int pulses, output int first, output int last);
    pulses = 0;
    first  = 0;
    last   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (enable === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
        last = i;
      end
    end
  endtask

  // dir must be unchanged across the edge that raises enable; enable never doubles up.
  logic dir_prev = 1'b0;
  logic en_prev  = 1'b0;
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      check("dir_hold", dir, dir_prev);
      check("en_single", en_prev, 0);
    end
    dir_prev = dir;
    en_prev  = enable;
  end

  initial begin
    int p, f, l, bad;

    repeat (3) @(negedge clk);
    check("rst_enable", enable, 0);
    check("rst_dir", dir, 0);
    check("rst_mode", mode, 0);
    reset = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (enable !== 1'b0 || dir !== 1'b0 || mode !== 1'b0) bad++;
    end
    check("idle_50", bad, 0);

    // manual step: pulse on the 7th falling edge after the press
    btn_step = 1'b1;
    run(20, p, f, l);
    check("step_count", p, 1);
    check("step_latency", f, 7);
    btn_step = 1'b0;
    run(10, p, f, l);
    check("step_release", p, 0);

    btn_step = 1'b1;
    run(3, p, f, l);
    btn_step = 1'b0;
    run(15, p, f, l);
    check("glitch_nopulse", p, 0);

    // enter AUTO
    btn_mode = 1'b1;
    run(6, p, f, l);
    check("mode_pre", mode, 0);
    run(1, p, f, l);
    check("mode_auto", mode, 1);
    check("mode_entry_nopulse", p, 0);
    btn_mode = 1'b0;
    run(25, p, f, l);
    check("auto_count", p, 3);
    check("auto_first", f, 8);
    check("auto_last", l, 24);

    // step press during AUTO is ignored
    run(3, p, f, l);
    check("auto_gap", p, 0);
    btn_step = 1'b1;
    run(12, p, f, l);
    check("auto_step_count", p, 2);
    check("auto_step_first", f, 4);
    check("auto_step_last", l, 12);
    btn_step = 1'b0;

    // leave AUTO on the edge a tick would fall due
    run(1, p, f, l);
    check("auto_pre_exit", p, 0);
    btn_mode = 1'b1;
    run(6, p, f, l);
    check("exit_pre_pulses", p, 0);
    check("exit_pre_mode", mode, 1);
    run(6, p, f, l);
    check("exit_suppressed", p, 0);
    check("exit_mode", mode, 0);
    btn_mode = 1'b0;
    run(20, p, f, l);
    check("manual_quiet", p, 0);

    // debounced sw_dir lands on the edge that raises enable
    btn_step = 1'b1;
    @(negedge clk);
    sw_dir = 1'b1;
    run(5, p, f, l);
    check("dir_pre_pulses", p, 0);
    @(negedge clk);
    check("dir_pulse_en", enable, 1);
    check("dir_pulse_dir", dir, 0);
    @(negedge clk);
    check("dir_after_en", enable, 0);
    check("dir_after_dir", dir, 1);
    btn_step = 1'b0;
    run(10, p, f, l);
    check("dir_tail", p, 0);

    // simultaneous mode and step presses: mode wins
    btn_mode = 1'b1;
    btn_step = 1'b1;
    run(7, p, f, l);
    check("simul_nopulse", p, 0);
    check("simul_mode", mode, 1);
    run(8, p, f, l);
    check("simul_auto_count", p, 1);
    check("simul_auto_first", f, 8);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    sw_dir   = 1'b0;
    run(5, p, f, l);
    check("pre_reset_pulses", p, 0);

    // reset in AUTO with prescaler at 5, mid-debounce on all inputs
    reset = 1'b0;
    #1;
    check("mid_rst_enable", enable, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_mode", mode, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (enable !== 1'b0 || dir !== 1'b0 || mode !== 1'b0) bad++;
    end
    check("rst_hold", bad, 0);
    reset = 1'b1;
    run(20, p, f, l);
    check("post_rst_quiet", p, 0);
    check("post_rst_mode", mode, 0);
    check("post_rst_dir", dir, 0);
    btn_step = 1'b1;
    run(12, p, f, l);
    check("post_rst_step_count", p, 1);
    check("post_rst_step_latency", f, 7);
    btn_step = 1'b0;
    run(10, p, f, l);
    check("post_rst_tail", p, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
